// File: rtl/cordic_fixedpoint_pkg.sv
// cordic_fixedpoint_pkg: shared widths, Q3.20 angle constants and phase-control FSM encoding
package cordic_fixedpoint_pkg;
    localparam int PHASE_IN_W = 23;
    localparam int PHASE_W    = 22;
    localparam int FRAC_W     = 20;
    localparam logic signed [PHASE_IN_W-1:0] PI      = 23'sd3294199;
    localparam logic signed [PHASE_IN_W-1:0] PI_HALF = 23'sd1647099;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLD,
        S_INIT,
        S_ITER,
        S_DONE
    } state_e;
endpackage

// File: rtl/cordic_fixedpoint_phasefold.sv
// cordic_fixedpoint_phasefold: folds a raw angle into [-pi/2, +pi/2] by +/-pi with result negation
// Optional CORDIC_PHASE_RANGE_CHECK_EN adds range_err_o and clamps |phase| to pi first.
module cordic_fixedpoint_phasefold
    import cordic_fixedpoint_pkg::*;
(
    input  logic [PHASE_IN_W-1:0] phase_i,
    output logic [PHASE_W-1:0]    normalize_o,
    output logic                  negate_o
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
    ,
    output logic                  range_err_o
`endif
);
    logic signed [PHASE_IN_W-1:0] p;

    always_comb begin
        p = $signed(phase_i);
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
        range_err_o = 1'b0;
        if (p > PI) begin
            p = PI;
            range_err_o = 1'b1;
        end else if (p < -PI) begin
            p = -PI;
            range_err_o = 1'b1;
        end
`endif
        negate_o = (p > PI_HALF) || (p < -PI_HALF);
        normalize_o = (p > PI_HALF) ? PHASE_W'(p - PI) :
                      (p < -PI_HALF) ? PHASE_W'(p + PI) : PHASE_W'(p);
    end
endmodule

// File: rtl/cordic_fixedpoint_phasectrl.sv
// cordic_fixedpoint_phasectrl: accepts an angle, folds it, then sequences init pulse and arctan ROM addresses
// Optional CORDIC_PHASE_RANGE_CHECK_EN adds the oRange_err output.
module cordic_fixedpoint_phasectrl
    import cordic_fixedpoint_pkg::*;
#(
    parameter int ITER   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iStart,
    input  logic [PHASE_IN_W-1:0] iPhase,
    output logic                  oReady,
    output logic                  oBusy,
    output logic                  oPhase_init_flag,
    output logic [PHASE_W-1:0]    oPhase_normalize,
    output logic [ADDR_W-1:0]     oPhase_addr,
    output logic                  oIter_valid,
    output logic                  oNegate,
    output logic                  oDone
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
    ,
    output logic                  oRange_err
`endif
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ITER - 1);

    if (ITER < 1 || ITER > 16 || (2 ** ADDR_W) < ITER) begin : g_bad_param
        $error("cordic_fixedpoint_phasectrl: illegal ITER/ADDR_W");
    end

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [PHASE_IN_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0]    norm_q, norm_d, fold_norm;
    logic                  neg_q, neg_d, fold_neg;
    logic                  ready_q, ready_d, busy_q, busy_d;
    logic                  init_q, init_d, valid_q, valid_d, done_q, done_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;

`ifdef CORDIC_PHASE_RANGE_CHECK_EN
    logic rerr_q, rerr_d, fold_rerr;

    cordic_fixedpoint_phasefold u_fold (
        .phase_i     (phase_q),
        .normalize_o (fold_norm),
        .negate_o    (fold_neg),
        .range_err_o (fold_rerr)
    );

    always_comb rerr_d = (state_q == S_FOLD) ? fold_rerr : rerr_q;

    always_ff @(posedge iClk)
        rerr_q <= iReset_n ? rerr_d : 1'b0;

    assign oRange_err = rerr_q;
`else
    cordic_fixedpoint_phasefold u_fold (
        .phase_i     (phase_q),
        .normalize_o (fold_norm),
        .negate_o    (fold_neg)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        norm_d  = norm_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: if (iStart) begin
                state_d = S_FOLD;
                phase_d = iPhase;
            end
            S_FOLD: begin
                state_d = S_INIT;
                norm_d  = fold_norm;
                neg_d   = fold_neg;
            end
            S_INIT: begin
                state_d = S_ITER;
                cnt_d   = '0;
            end
            S_ITER: if (cnt_q == LAST) state_d = S_DONE;
                    else cnt_d = cnt_q + ADDR_W'(1);
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
        init_d  = (state_d == S_INIT);
        valid_d = (state_d == S_ITER);
        done_d  = (state_d == S_DONE);
        addr_d  = valid_d ? cnt_d : '0;
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            norm_q  <= '0;
            neg_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            norm_q  <= norm_d;
            neg_q   <= neg_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            init_q  <= init_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    assign oReady           = ready_q;
    assign oBusy            = busy_q;
    assign oPhase_init_flag = init_q;
    assign oPhase_normalize = norm_q;
    assign oPhase_addr      = addr_q;
    assign oIter_valid      = valid_q;
    assign oNegate          = neg_q;
    assign oDone            = done_q;
endmodule

// File: tb/tb_cordic_fixedpoint_phasectrl.sv
// tb_cordic_fixedpoint_phasectrl: cycle-level model comparison plus hand-computed fold/latency expectations
module tb_cordic_fixedpoint_phasectrl;
    localparam int ITER   = 16;
    localparam int ADDR_W = 4;
    localparam int PI     = 3294199;
    localparam int PH     = 1647099;

    logic              iClk = 1'b0;
    logic              iReset_n, iStart;
    logic [22:0]       iPhase;
    logic              oReady, oBusy, oPhase_init_flag, oIter_valid, oNegate, oDone;
    logic [21:0]       oPhase_normalize;
    logic [ADDR_W-1:0] oPhase_addr;
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
    logic              oRange_err;
`endif

    int checks = 0;
    int errors = 0;
    int md = -1;
    int mph = 0;
    int mnorm = 0;
    bit mneg = 1'b0;
    bit mrerr = 1'b0;

    cordic_fixedpoint_phasectrl #(.ITER(ITER), .ADDR_W(ADDR_W)) dut (
        .iClk             (iClk),
        .iReset_n         (iReset_n),
        .iStart           (iStart),
        .iPhase           (iPhase),
        .oReady           (oReady),
        .oBusy            (oBusy),
        .oPhase_init_flag (oPhase_init_flag),
        .oPhase_normalize (oPhase_normalize),
        .oPhase_addr      (oPhase_addr),
        .oIter_valid      (oIter_valid),
        .oNegate          (oNegate),
        .oDone            (oDone)
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
        ,
        .oRange_err       (oRange_err)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic void mfold(input int ph, output int n, output bit ng, output bit re);
        re = 1'b0;
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
        if (ph > PI) begin ph = PI; re = 1'b1; end
        else if (ph < -PI) begin ph = -PI; re = 1'b1; end
`endif
        if (ph > PH) begin n = ph - PI; ng = 1'b1; end
        else if (ph < -PH) begin n = ph + PI; ng = 1'b1; end
        else begin n = ph; ng = 1'b0; end
    endfunction

    // md counts cycles since accept: 0 fold, 1 init, 2..ITER+1 iterate, ITER+2 done, -1 idle.
    always begin
        @(posedge iClk);
        if (!iReset_n) begin
            md = -1; mph = 0; mnorm = 0; mneg = 1'b0; mrerr = 1'b0;
        end else if (md < 0) begin
            if (iStart) begin md = 0; mph = $signed(iPhase); end
        end else begin
            md++;
            if (md == 1) mfold(mph, mnorm, mneg, mrerr);
            if (md == ITER + 3) md = -1;
        end
        #1;
        chk("ready", int'(oReady), int'(md < 0));
        chk("busy", int'(oBusy), int'(md >= 0));
        chk("init_flag", int'(oPhase_init_flag), int'(md == 1));
        chk("iter_valid", int'(oIter_valid), int'(md >= 2 && md <= ITER + 1));
        chk("addr", int'(oPhase_addr), (md >= 2 && md <= ITER + 1) ? md - 2 : 0);
        chk("done", int'(oDone), int'(md == ITER + 2));
        chk("normalize", int'($signed(oPhase_normalize)), mnorm);
        chk("negate", int'(oNegate), int'(mneg));
`ifdef CORDIC_PHASE_RANGE_CHECK_EN
        chk("range_err", int'(oRange_err), int'(mrerr));
`endif
    end

    task automatic wait_ready();
        int n = 0;
        while (!oReady && n < 50) begin @(negedge iClk); n++; end
        if (!oReady) tmo("ready_wait");
    endtask

    task automatic run(input int ph, input int en, input int eneg);
        int n;
        wait_ready();
        iStart = 1'b1;
        iPhase = 23'(ph);
        @(negedge iClk);
        iStart = 1'b0;
        n = 1;
        while (!oDone && n < 60) begin
            @(negedge iClk);
            n++;
            if (n == 2) chk("init_lit", int'(oPhase_init_flag), 1);
        end
        if (!oDone) tmo("done_wait");
        else begin
            chk("latency_lit", n, 3 + ITER);
            chk("norm_lit", int'($signed(oPhase_normalize)), en);
            chk("neg_lit", int'(oNegate), eneg);
        end
        @(negedge iClk);
    endtask

    initial begin
        int dn, n;
        iReset_n = 1'b0;
        iStart = 1'b0;
        iPhase = '0;
        repeat (3) @(negedge iClk);
        chk("reset_ready", int'(oReady), 1);
        chk("reset_done", int'(oDone), 0);
        iReset_n = 1'b1;
        @(negedge iClk);

        run(0, 0, 0);
        run(2097152, -1197047, 1);
        run(-2097152, 1197047, 1);
        run(1647099, 1647099, 0);
        run(-1647099, -1647099, 0);
        run(1647100, -1647099, 1);

        // Start held high: back-to-back accepts, phase change mid-ITER only affects the next one.
        wait_ready();
        iStart = 1'b1;
        iPhase = 23'(2097152);
        dn = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge iClk);
            if (oDone) dn++;
            if (i == 10) begin
                iPhase = 23'(-2097152);
                chk("hold_norm1", int'($signed(oPhase_normalize)), -1197047);
            end
        end
        iStart = 1'b0;
        chk("hold_dones", dn, 2);
        chk("hold_norm2", int'($signed(oPhase_normalize)), 1197047);

        // A start pulse while busy must be ignored.
        wait_ready();
        iStart = 1'b1;
        iPhase = '0;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (4) @(negedge iClk);
        iStart = 1'b1;
        iPhase = 23'(2097152);
        @(negedge iClk);
        iStart = 1'b0;
        repeat (20) @(negedge iClk);
        chk("busy_ign_ready", int'(oReady), 1);
        chk("busy_ign_norm", int'($signed(oPhase_normalize)), 0);

        // Reset in the middle of ITER aborts without a done pulse.
        wait_ready();
        iStart = 1'b1;
        iPhase = 23'(2097152);
        @(negedge iClk);
        iStart = 1'b0;
        n = 0;
        while (!(oIter_valid && oPhase_addr == 7) && n < 30) begin @(negedge iClk); n++; end
        if (!(oIter_valid && oPhase_addr == 7)) tmo("addr7_wait");
        iReset_n = 1'b0;
        @(negedge iClk);
        chk("rst_ready", int'(oReady), 1);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_addr", int'(oPhase_addr), 0);
        chk("rst_valid", int'(oIter_valid), 0);
        chk("rst_norm", int'($signed(oPhase_normalize)), 0);
        chk("rst_neg", int'(oNegate), 0);
        iReset_n = 1'b1;
        dn = 0;
        repeat (25) begin @(negedge iClk); if (oDone) dn++; end
        chk("rst_no_done", dn, 0);

`ifdef CORDIC_PHASE_RANGE_CHECK_EN
        run(3400000, 0, 1);
        chk("rerr_lit1", int'(oRange_err), 1);
        run(3294199, 0, 1);
        chk("rerr_lit0", int'(oRange_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
